// File: rtl/insn_encoder_loader_if.sv
// Instruction loader bus: start/base, instruction-field handshake,
// instruction-memory write port and status.
//   slave  : loader view (takes fields and im_busy, drives write port/status)
//   master : driver/environment view
interface insn_encoder_loader_if;
   logic        start;
   logic [31:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_mnem;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_sa;
   logic [15:0] in_imm;
   logic [25:0] in_tgt;
   logic        im_busy;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  count;

   modport slave (
      input  start, base_addr, in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa,
             in_imm, in_tgt, im_busy,
      output in_ready, im_we, im_addr, im_wdata, busy, done, err, count
   );

   modport master (
      output start, base_addr, in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa,
             in_imm, in_tgt, im_busy,
      input  in_ready, im_we, im_addr, im_wdata, busy, done, err, count
   );
endinterface

// File: rtl/insn_encoder_loader.sv
// Instruction encoder/loader: encodes mnemonic fields into MIPS-style words
// and streams them through a 4-entry FIFO into instruction memory.
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - insn_encoder_loader_if.slave (start/base_addr, in_* handshake,
//           im_busy in; im_we/im_addr/im_wdata, busy/done/err/count out)
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting fields and writing words to memory
// DONE   | HALT word written; done held until next start
// ERR    | illegal mnemonic accepted; FIFO flushed, err held
module insn_encoder_loader (
   input logic                  CLK,
   input logic                  nRST,
   insn_encoder_loader_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [2:0]  fill_q, fill_d;
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  count_q, count_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        halt_seen_q, halt_seen_d;
   logic [31:0] fifo_q [4];

   logic        start_acc, in_ready, accept, illegal, push, pop, halt_write;
   logic        is_sll;
   logic [5:0]  enc_op, enc_funct;
   logic [31:0] enc_word;

   assign start_acc = bus.start && (state_q != S_LOAD);
   assign in_ready  = (state_q == S_LOAD) && (fill_q != 3'd4) && !halt_seen_q;
   assign accept    = bus.in_valid && in_ready;
   assign illegal   = accept && (bus.in_mnem == 4'd15);
   assign push      = accept && !illegal;
   assign pop       = (fill_q != 3'd0) && !bus.im_busy && (state_q == S_LOAD);
   // HALT is always the last word queued, so once it has been accepted the
   // pop that empties the FIFO is the HALT write.
   assign halt_write = pop && halt_seen_q && (fill_q == 3'd1);

   always_comb begin
      enc_op    = 6'b000000;
      enc_funct = 6'b000000;
      case (bus.in_mnem)
         4'd0:    enc_funct = 6'b100000;
         4'd1:    enc_funct = 6'b100010;
         4'd2:    enc_funct = 6'b100100;
         4'd3:    enc_funct = 6'b100101;
         4'd4:    enc_funct = 6'b000000;
         4'd5:    enc_funct = 6'b101010;
         4'd6:    enc_op    = 6'b001000;
         4'd7:    enc_op    = 6'b001101;
         4'd8:    enc_op    = 6'b101011;
         4'd9:    enc_op    = 6'b100011;
         4'd10:   enc_op    = 6'b000100;
         4'd11:   enc_op    = 6'b000101;
         4'd12:   enc_op    = 6'b000111;
         4'd13:   enc_op    = 6'b000010;
         default: enc_op    = 6'b111111;
      endcase
   end

   assign is_sll = (bus.in_mnem == 4'd4);

   always_comb begin
      if (bus.in_mnem <= 4'd5)
         enc_word = {enc_op, is_sll ? 5'd0 : bus.in_rs, bus.in_rt, bus.in_rd,
                     is_sll ? bus.in_sa : 5'd0, enc_funct};
      else if (bus.in_mnem <= 4'd11)
         enc_word = {enc_op, bus.in_rs, bus.in_rt, bus.in_imm};
      else if (bus.in_mnem == 4'd12)
         enc_word = {enc_op, bus.in_rs, 5'd0, bus.in_imm};
      else if (bus.in_mnem == 4'd13)
         enc_word = {enc_op, bus.in_tgt};
      else
         enc_word = 32'hFC00_0000;
   end

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      count_d     = count_q;
      done_d      = done_q;
      err_d       = err_q;
      halt_seen_d = halt_seen_q;
      if (start_acc) begin
         state_d     = S_LOAD;
         fill_d      = 3'd0;
         rd_d        = 2'd0;
         wr_d        = 2'd0;
         addr_d      = bus.base_addr;
         count_d     = 8'd0;
         done_d      = 1'b0;
         err_d       = 1'b0;
         halt_seen_d = 1'b0;
      end else if (state_q == S_LOAD) begin
         if (pop) begin
            rd_d   = rd_q + 2'd1;
            addr_d = addr_q + 32'd4;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
         end
         if (push) begin
            wr_d = wr_q + 2'd1;
            if (bus.in_mnem == 4'd14) halt_seen_d = 1'b1;
         end
         fill_d = fill_q + {2'b00, push} - {2'b00, pop};
         if (illegal) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            fill_d  = 3'd0;
            rd_d    = 2'd0;
            wr_d    = 2'd0;
         end else if (halt_write) begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         fill_q      <= 3'd0;
         rd_q        <= 2'd0;
         wr_q        <= 2'd0;
         addr_q      <= 32'd0;
         count_q     <= 8'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         halt_seen_q <= 1'b0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= 32'd0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         done_q      <= done_d;
         err_q       <= err_d;
         halt_seen_q <= halt_seen_d;
         if (push) fifo_q[wr_q] <= enc_word;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.im_we    = pop;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = fifo_q[rd_q];
   assign bus.busy     = (state_q == S_LOAD);
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.count    = count_q;

endmodule

// File: tb/tb_insn_encoder_loader.sv
module tb_insn_encoder_loader;
   logic CLK  = 1'b0;
   logic nRST = 1'b1;

   insn_encoder_loader_if bus ();

   insn_encoder_loader dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] naddr;

   int unsigned op_tab [16] = '{0, 0, 0, 0, 0, 0, 8, 13, 43, 35, 4, 5, 7, 2, 63, 63};
   int unsigned fn_tab [6]  = '{32, 34, 36, 37, 0, 42};

   // Reference encoding from the instruction-format rules, by field weights.
   function automatic logic [31:0] ref_encode(input logic [3:0] m,
         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
         input logic [4:0] sa, input logic [15:0] imm, input logic [25:0] tgt);
      int unsigned vrs, vrt, vrd, vsa, vim, vtg, w;
      vrs = 32'(rs); vrt = 32'(rt); vrd = 32'(rd); vsa = 32'(sa);
      vim = 32'(imm); vtg = 32'(tgt);
      if (m <= 4'd5) begin
         if (m == 4'd4) vrs = 0;
         else           vsa = 0;
         w = op_tab[m] * 32'h0400_0000 + vrs * 32'h0020_0000 + vrt * 32'h0001_0000
           + vrd * 32'h0000_0800 + vsa * 32'd64 + fn_tab[m];
      end else if (m <= 4'd12) begin
         if (m == 4'd12) vrt = 0;
         w = op_tab[m] * 32'h0400_0000 + vrs * 32'h0020_0000 + vrt * 32'h0001_0000 + vim;
      end else if (m == 4'd13) begin
         w = op_tab[m] * 32'h0400_0000 + vtg;
      end else begin
         w = 63 * 32'h0400_0000;
      end
      return w;
   endfunction

   task automatic idle_inputs;
      bus.start = 1'b0; bus.base_addr = 32'd0; bus.in_valid = 1'b0;
      bus.in_mnem = 4'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_rd = 5'd0;
      bus.in_sa = 5'd0; bus.in_imm = 16'd0; bus.in_tgt = 26'd0; bus.im_busy = 1'b0;
   endtask

   task automatic set_fields(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
         input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm, input logic [25:0] tgt);
      bus.in_mnem = m; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.in_sa = sa; bus.in_imm = imm; bus.in_tgt = tgt;
   endtask

   task automatic rand_fields(input logic [3:0] m);
      set_fields(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom));
   endtask

   task automatic apply_reset;
      @(posedge CLK); #1;
      nRST = 1'b0;
      idle_inputs();
      @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   task automatic drive_start(input logic [31:0] b);
      bus.start = 1'b1; bus.base_addr = b;
      @(posedge CLK); #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      #1 nRST = 1'b0;
      #2;
      n_checks++; if (bus.im_we !== 1'b0) begin n_fail++; $display("FAIL rst_im_we: got %b want 0", bus.im_we); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
      n_checks++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %h want 00", bus.count); end
      n_checks++; if (bus.im_addr !== 32'd0) begin n_fail++; $display("FAIL rst_im_addr: got %h want 0", bus.im_addr); end
      n_checks++; if (bus.im_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_im_wdata: got %h want 0", bus.im_wdata); end
      @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   task automatic test_basic;
      apply_reset();
      drive_start(32'h0000_0000);
      set_fields(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0008, 26'd0);
      bus.in_valid = 1'b1;
      @(negedge CLK);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", bus.in_ready); end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      @(negedge CLK);
      n_checks++; if (bus.im_we !== 1'b1) begin n_fail++; $display("FAIL basic_we: got %b want 1", bus.im_we); end
      n_checks++; if (bus.im_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h want 00000000", bus.im_addr); end
      n_checks++; if (bus.im_wdata !== 32'h2001_0008) begin n_fail++; $display("FAIL basic_data: got %h want 20010008", bus.im_wdata); end
      @(posedge CLK); #1;
      n_checks++; if (bus.count !== 8'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", bus.count); end
      n_checks++; if (bus.im_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_after: got %b want 0", bus.im_we); end
   endtask

   task automatic test_rtype;
      apply_reset();
      drive_start(32'h0000_0000);
      set_fields(4'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'd0);
      bus.in_valid = 1'b1;
      @(posedge CLK); #1;
      set_fields(4'd4, 5'd9, 5'd2, 5'd3, 5'd2, 16'h0, 26'd0);
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'h0, 32'h0022_1820})
         begin n_fail++; $display("FAIL rtype_add: got we %b addr %h data %h want 1 00000000 00221820", bus.im_we, bus.im_addr, bus.im_wdata); end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'h4, 32'h0002_1880})
         begin n_fail++; $display("FAIL rtype_sll: got we %b addr %h data %h want 1 00000004 00021880", bus.im_we, bus.im_addr, bus.im_wdata); end
      @(posedge CLK); #1;
      n_checks++; if (bus.count !== 8'd2) begin n_fail++; $display("FAIL rtype_count: got %0d want 2", bus.count); end
   endtask

   task automatic test_backpressure;
      int k, nw;
      int wcyc [5];
      bit acc;
      logic [63:0] e;
      k = 0; nw = 0;
      apply_reset();
      drive_start(32'h0000_0100);
      naddr = 32'h100; exp_q.delete();
      bus.im_busy = 1'b1;
      rand_fields(4'($urandom_range(13)));
      bus.in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         acc = bus.in_ready;
         if (c == 5) begin
            n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", k); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
            n_checks++; if (bus.im_we !== 1'b0) begin n_fail++; $display("FAIL bp_we_busy: got %b want 0", bus.im_we); end
         end
         @(posedge CLK); #1;
         if (acc) begin
            exp_q.push_back({naddr, ref_encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_sa, bus.in_imm, bus.in_tgt)});
            naddr += 32'd4; k++;
            rand_fields(4'($urandom_range(13)));
         end
      end
      bus.im_busy = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         acc = bus.in_valid && bus.in_ready;
         if (bus.im_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL bp_write: unexpected write addr %h data %h", bus.im_addr, bus.im_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({bus.im_addr, bus.im_wdata} !== e) begin
                  n_fail++; $display("FAIL bp_write: got addr %h data %h want addr %h data %h", bus.im_addr, bus.im_wdata, e[63:32], e[31:0]);
               end
            end
            if (nw < 5) wcyc[nw] = c;
            nw++;
         end
         @(posedge CLK); #1;
         if (acc) begin
            exp_q.push_back({naddr, ref_encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_sa, bus.in_imm, bus.in_tgt)});
            naddr += 32'd4; k++;
            bus.in_valid = 1'b0;
         end
      end
      n_checks++; if (nw != 5) begin n_fail++; $display("FAIL bp_num_writes: got %0d want 5", nw); end
      n_checks++; if (nw >= 4 && (wcyc[0] != 0 || wcyc[3] != 3)) begin n_fail++; $display("FAIL bp_consecutive: got first %0d fourth %0d want 0 3", wcyc[0], wcyc[3]); end
      n_checks++; if (k != 5) begin n_fail++; $display("FAIL bp_fifth: got %0d accepted want 5", k); end
   endtask

   task automatic test_halt;
      apply_reset();
      drive_start(32'h0000_0000);
      set_fields(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
      bus.in_valid = 1'b1;
      @(negedge CLK);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL halt_busy_load: got %b want 1", bus.busy); end
      @(posedge CLK); #1;
      set_fields(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0);
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'h0, 32'h0800_0010})
         begin n_fail++; $display("FAIL halt_j: got we %b addr %h data %h want 1 00000000 08000010", bus.im_we, bus.im_addr, bus.im_wdata); end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'h4, 32'hFC00_0000})
         begin n_fail++; $display("FAIL halt_word: got we %b addr %h data %h want 1 00000004 fc000000", bus.im_we, bus.im_addr, bus.im_wdata); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready_after_accept: got %b want 0", bus.in_ready); end
      @(posedge CLK); #1;
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b want 1", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.count !== 8'd2) begin n_fail++; $display("FAIL halt_count: got %0d want 2", bus.count); end
   endtask

   // Runs straight after test_halt, so the start is taken from DONE.
   task automatic test_wrap;
      drive_start(32'hFFFF_FFFC);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL wrap_done_clr: got %b want 0", bus.done); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy: got %b want 1", bus.busy); end
      set_fields(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0008, 26'd0);
      bus.in_valid = 1'b1;
      @(posedge CLK); #1;
      set_fields(4'd7, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0);
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'hFFFF_FFFC, 32'h2001_0008})
         begin n_fail++; $display("FAIL wrap_first: got we %b addr %h data %h want 1 fffffffc 20010008", bus.im_we, bus.im_addr, bus.im_wdata); end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      @(negedge CLK);
      n_checks++; if ({bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 32'h0, 32'h3443_BEEF})
         begin n_fail++; $display("FAIL wrap_second: got we %b addr %h data %h want 1 00000000 3443beef", bus.im_we, bus.im_addr, bus.im_wdata); end
      @(posedge CLK); #1;
   endtask

   task automatic test_err;
      apply_reset();
      drive_start(32'h0000_0000);
      bus.im_busy = 1'b1;
      rand_fields(4'($urandom_range(13)));
      bus.in_valid = 1'b1;
      @(posedge CLK); #1;
      rand_fields(4'($urandom_range(13)));
      @(posedge CLK); #1;
      rand_fields(4'd15);
      @(negedge CLK);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b want 1", bus.in_ready); end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      bus.im_busy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         n_checks++; if (bus.im_we !== 1'b0) begin n_fail++; $display("FAIL err_no_write: got %b want 0 at cycle %0d", bus.im_we, c); end
      end
      n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", bus.err); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL err_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL err_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL err_count: got %0d want 0", bus.count); end
      @(posedge CLK); #1;
      drive_start(32'h0000_0020);
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", bus.err); end
      n_checks++; if (bus.im_addr !== 32'h20) begin n_fail++; $display("FAIL err_restart_addr: got %h want 00000020", bus.im_addr); end
   endtask

   task automatic test_reset_midload;
      apply_reset();
      drive_start(32'h0000_0040);
      bus.im_busy = 1'b1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rand_fields(4'($urandom_range(13)));
         @(posedge CLK); #1;
      end
      bus.in_valid = 1'b0;
      bus.im_busy = 1'b0;
      @(posedge CLK); #1;
      n_checks++; if (bus.count !== 8'd1) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 1", bus.count); end
      nRST = 1'b0;
      #1;
      n_checks++; if (bus.im_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b want 0", bus.im_we); end
      n_checks++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", bus.count); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.im_addr !== 32'd0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", bus.im_addr); end
      @(posedge CLK); #1;
      nRST = 1'b1;
      rand_fields(4'($urandom_range(13)));
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         n_checks++; if ({bus.in_ready, bus.im_we} !== 2'b00) begin n_fail++; $display("FAIL mid_no_start: got ready/we %b want 00", {bus.in_ready, bus.im_we}); end
      end
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_random;
      int n_words, sent, budget;
      bit halted, done_seen, acc;
      logic [63:0] e;
      logic [31:0] base;
      n_words = 30; sent = 0; budget = 0;
      halted = 1'b0; done_seen = 1'b0;
      apply_reset();
      base = $urandom;
      drive_start(base);
      naddr = base; exp_q.delete();
      rand_fields(4'($urandom_range(13)));
      bus.in_valid = 1'b1;
      while (!done_seen && budget < 2000) begin
         @(negedge CLK);
         acc = bus.in_valid && bus.in_ready;
         if (bus.im_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_write: unexpected write addr %h data %h", bus.im_addr, bus.im_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({bus.im_addr, bus.im_wdata} !== e) begin
                  n_fail++; $display("FAIL rand_write: got addr %h data %h want addr %h data %h", bus.im_addr, bus.im_wdata, e[63:32], e[31:0]);
               end
            end
         end
         if (acc) begin
            exp_q.push_back({naddr, ref_encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_sa, bus.in_imm, bus.in_tgt)});
            naddr += 32'd4;
            sent++;
            if (bus.in_mnem == 4'd14) halted = 1'b1;
         end
         @(posedge CLK); #1;
         done_seen = bus.done;
         budget++;
         bus.im_busy = ($urandom_range(2) == 0);
         if (halted) begin
            bus.in_valid = 1'b0;
         end else if (acc || !bus.in_valid) begin
            if ($urandom_range(3) == 0) begin
               bus.in_valid = 1'b0;
            end else begin
               bus.in_valid = 1'b1;
               rand_fields((sent == n_words) ? 4'd14 : 4'($urandom_range(13)));
            end
         end
      end
      bus.im_busy = 1'b0;
      n_checks++; if (!done_seen) begin n_fail++; $display("FAIL rand_timeout: done not seen after %0d cycles", budget); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_pending: got %0d unwritten words want 0", exp_q.size()); end
      n_checks++; if (bus.count !== 8'(n_words + 1)) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", bus.count, n_words + 1); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b want 0", bus.busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rtype();
      test_backpressure();
      test_halt();
      test_wrap();
      test_err();
      test_reset_midload();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
